// File: rtl/div_fu.sv
// RV32M DIV/DIVU/REM/REMU unit, two restoring steps per cycle.
// It answers at a fixed LATENCY so the issuer's write-back slot lines up with done.
module div_fu #(
  parameter int unsigned LATENCY = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        EN,
  input  logic [1:0]  op,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic [31:0] res,
  output logic        done,
  output logic        busy
);

  localparam int unsigned   CW           = $clog2(LATENCY);
  localparam logic [CW-1:0] CNT_LAST     = CW'(LATENCY - 1);
  localparam logic [CW-1:0] CNT_ITER_END = CW'(16);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_FIX,
    S_WAIT,
    S_DONE
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [1:0]    op_q;
  logic [31:0]   a_q;
  logic [31:0]   b_q;
  logic [31:0]   dvs_q;
  logic [63:0]   rq_q;
  logic          sgn_quo_q;
  logic          sgn_rem_q;
  logic          dz_q;
  logic          ovf_q;
  logic [31:0]   result_q;
  logic [31:0]   res_q;
  logic          done_q;
  logic          busy_q;

  logic          is_signed;
  logic [31:0]   abs_a;
  logic [31:0]   abs_b;
  logic          accept;
  logic          last_d;
  logic [2:0][63:0] stage;
  logic [31:0]   fix_iter;
  logic [31:0]   fix_rq;

  assign is_signed = ~op_q[0];
  // Magnitude of 0x80000000 wraps back to itself, which is correct as unsigned.
  assign abs_a     = (is_signed && a_q[31]) ? (~a_q + 32'd1) : a_q;
  assign abs_b     = (is_signed && b_q[31]) ? (~b_q + 32'd1) : b_q;
  assign cnt_d     = cnt_q + CW'(1);
  assign last_d    = (cnt_d == CNT_LAST);
  assign accept    = EN && ((state_q == S_IDLE) || (state_q == S_DONE));

  // Two chained restoring steps; the 33-bit trial keeps the bit shifted out of rem.
  assign stage[0] = rq_q;
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_step
      logic [33:0] diff;
      assign diff = {1'b0, stage[gi][63:31]} - {2'b00, dvs_q};
      assign stage[gi+1] = diff[33] ? {stage[gi][62:0], 1'b0}
                                    : {diff[31:0], stage[gi][30:0], 1'b1};
    end
  endgenerate

  function automatic logic [31:0] finish_result(
    input logic [63:0] rq,
    input logic [1:0]  opc,
    input logic [31:0] a_raw,
    input logic        dz,
    input logic        ovf,
    input logic        sq,
    input logic        sr
  );
    logic [31:0] q;
    logic [31:0] r;
    q = rq[31:0];
    r = rq[63:32];
    if (dz) begin
      q = 32'hFFFF_FFFF;
      r = a_raw;
    end else if (ovf) begin
      q = 32'h8000_0000;
      r = 32'h0000_0000;
    end else if (!opc[0]) begin
      if (sq) q = ~q + 32'd1;
      if (sr) r = ~r + 32'd1;
    end
    return opc[1] ? r : q;
  endfunction

  assign fix_iter = finish_result(stage[2], op_q, a_q, dz_q, ovf_q, sgn_quo_q, sgn_rem_q);
  assign fix_rq   = finish_result(rq_q,     op_q, a_q, dz_q, ovf_q, sgn_quo_q, sgn_rem_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      dvs_q     <= '0;
      rq_q      <= '0;
      sgn_quo_q <= 1'b0;
      sgn_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      ovf_q     <= 1'b0;
      result_q  <= '0;
      res_q     <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (accept) begin
            op_q    <= op;
            a_q     <= rs1_data;
            b_q     <= rs2_data;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_PREP;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_PREP: begin
          cnt_q     <= cnt_d;
          rq_q      <= {32'h0000_0000, abs_a};
          dvs_q     <= abs_b;
          sgn_quo_q <= is_signed & (a_q[31] ^ b_q[31]);
          sgn_rem_q <= is_signed & a_q[31];
          dz_q      <= (b_q == 32'h0000_0000);
          ovf_q     <= is_signed && (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
          state_q   <= S_ITER;
        end
        S_ITER: begin
          cnt_q <= cnt_d;
          rq_q  <= stage[2];
          if (cnt_q == CNT_ITER_END) begin
            // Only reachable at the minimum latency, where FIX would collide with DONE.
            if (last_d) begin
              res_q   <= fix_iter;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= S_FIX;
            end
          end
        end
        S_FIX: begin
          cnt_q    <= cnt_d;
          result_q <= fix_rq;
          if (last_d) begin
            res_q   <= fix_rq;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_d;
          if (last_d) begin
            res_q   <= result_q;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign res  = res_q;
  assign done = done_q;
  assign busy = busy_q;

endmodule
